// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time via a req/ready handshake, with
// WAIT_STATES busy cycles, byte-lane merging on stores and lane extraction on loads.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  DMType,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);
    // state | meaning
    // IDLE  | waiting for req; request fields captured on acceptance
    // BUSY  | counting down wait states; access performed when cnt reaches 0
    // RESP  | ready/err/rdata presented for exactly one cycle
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    state_t state, state_nxt;
    logic [3:0] cnt;
    logic do_latch, do_dec, do_access;

    logic                  lat_w;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [1:0]            lat_lane;
    logic [31:0]           lat_wdata;
    logic [2:0]            lat_type;

    logic [31:0] mem [DEPTH];
    logic [31:0] cur_word, lane_data, merged, ld_val;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [3:0]  be;
    logic        mis, bad_type, acc_err;

    // Upper address bits are deliberately ignored so addresses alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        do_latch  = (state == IDLE) && req;
        do_dec    = (state == BUSY) && (cnt != 4'd0);
        do_access = (state == BUSY) && (cnt == 4'd0);
    end

    always_comb begin
        cur_word  = mem[lat_idx];
        half_sel  = lat_lane[1] ? cur_word[31:16] : cur_word[15:0];
        case (lat_lane)
            2'd0:    byte_sel = cur_word[7:0];
            2'd1:    byte_sel = cur_word[15:8];
            2'd2:    byte_sel = cur_word[23:16];
            default: byte_sel = cur_word[31:24];
        endcase
        mis       = 1'b0;
        bad_type  = 1'b0;
        be        = 4'b0000;
        lane_data = lat_wdata;
        ld_val    = 32'd0;
        // Bit 0 of a legal non-word type distinguishes signed (1) from unsigned (0).
        case (lat_type)
            3'b000: begin
                mis    = (lat_lane != 2'b00);
                be     = 4'b1111;
                ld_val = cur_word;
            end
            3'b001, 3'b010: begin
                mis       = lat_lane[0];
                be        = lat_lane[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{lat_wdata[15:0]}};
                ld_val    = lat_type[0] ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            end
            3'b011, 3'b100: begin
                be        = 4'b0001 << lat_lane;
                lane_data = {4{lat_wdata[7:0]}};
                ld_val    = lat_type[0] ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            end
            default: bad_type = 1'b1;
        endcase
        acc_err = mis | bad_type;
        merged  = cur_word;
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (do_access && lat_w && !acc_err) mem[lat_idx] <= merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            lat_w     <= 1'b0;
            lat_idx   <= '0;
            lat_lane  <= 2'd0;
            lat_wdata <= 32'd0;
            lat_type  <= 3'd0;
        end else begin
            ready <= do_access;
            if (do_latch) begin
                cnt       <= WS;
                lat_w     <= mem_w;
                lat_idx   <= addr[ADDR_WIDTH+1:2];
                lat_lane  <= addr[1:0];
                lat_wdata <= wdata;
                lat_type  <= DMType;
            end else if (do_dec) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                err <= acc_err;
                if (!lat_w) rdata <= acc_err ? 32'd0 : ld_val;
            end else if (state == RESP) begin
                err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, back-to-back,
// randomized traffic against a byte-array model, and a WAIT_STATES=3 reset-abort check.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req3, mem_w;
    logic [31:0] addr, wdata;
    logic [2:0]  dmtype;
    logic [31:0] rdata1, rdata3;
    logic        ready1, ready3, err1, err3;
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;

    dmem_responder #(.ADDR_WIDTH(7), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .mem_w(mem_w), .addr(addr), .wdata(wdata),
        .DMType(dmtype), .rdata(rdata1), .ready(ready1), .err(err1));

    dmem_responder #(.ADDR_WIDTH(7), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .mem_w(mem_w), .addr(addr), .wdata(wdata),
        .DMType(dmtype), .rdata(rdata3), .ready(ready3), .err(err3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  t;
        logic [31:0] exp_rd;
        logic        exp_e;
        logic        chk_rd;
    } vec_t;

    vec_t vecs[24];

    // Reference model: byte-addressed memory plus the last completed load value.
    logic [7:0]  mb [512];
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] t, output logic [31:0] rd_exp,
                                  output logic e_exp);
        int size, ba;
        logic [31:0] v;
        size = (t == 3'd0) ? 4 : (t == 3'd1 || t == 3'd2) ? 2 : (t == 3'd3 || t == 3'd4) ? 1 : 0;
        ba = int'(a % 512);
        e_exp = (size == 0) ? 1'b1 : ((ba % size) != 0);
        if (w) begin
            if (!e_exp)
                for (int i = 0; i < size; i++) mb[ba+i] = d[8*i +: 8];
        end else if (e_exp) begin
            last_rd = 32'd0;
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mb[ba+i]) << (8*i));
            if ((t == 3'd1 || t == 3'd3) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            last_rd = v;
        end
        rd_exp = last_rd;
    endfunction

    // One complete access; lat is the number of edges from acceptance to ready (-1 on timeout).
    task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] t, output logic [31:0] rd, output logic e,
                          output int lat);
        @(negedge clk);
        mem_w = w; addr = a; wdata = d; dmtype = t;
        if (sel == 0) req1 = 1'b1; else req3 = 1'b1;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? ready1 : ready3) begin
                lat = n;
                break;
            end
        end
        rd = (sel == 0) ? rdata1 : rdata3;
        e  = (sel == 0) ? err1 : err3;
        req1 = 1'b0; req3 = 1'b0;
        @(posedge clk); #1;
        check("ready_one_cycle", 32'((sel == 0) ? ready1 : ready3), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, erd, w32, a32;
        logic        e, ee, wr, seen;
        logic [2:0]  tt;
        int          lat, c1, c2;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'd0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        3'd0, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h11,  32'h000000A5, 3'd3, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,        3'd0, 32'hDEADA5EF, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h11,  32'h0,        3'd3, 32'hFFFFFFA5, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 32'h11,  32'h0,        3'd4, 32'h000000A5, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 32'h12,  32'h00008001, 3'd1, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h10,  32'h0,        3'd0, 32'h8001A5EF, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 32'h12,  32'h0,        3'd1, 32'hFFFF8001, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 32'h12,  32'h0,        3'd2, 32'h00008001, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h13,  32'h0,        3'd3, 32'hFFFFFF80, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'h13,  32'h11111111, 3'd0, 32'h0,        1'b1, 1'b0};
        vecs[12] = '{1'b0, 32'h10,  32'h0,        3'd0, 32'h8001A5EF, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 32'h11,  32'h0,        3'd1, 32'h0,        1'b1, 1'b1};
        vecs[14] = '{1'b0, 32'h10,  32'h0,        3'd7, 32'h0,        1'b1, 1'b1};
        vecs[15] = '{1'b1, 32'h10,  32'h0,        3'd7, 32'h0,        1'b1, 1'b0};
        vecs[16] = '{1'b0, 32'h10,  32'h0,        3'd0, 32'h8001A5EF, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 32'h10,  32'hFFFF1234, 3'd2, 32'h0,        1'b0, 1'b0};
        vecs[18] = '{1'b0, 32'h10,  32'h0,        3'd0, 32'h80011234, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 32'h13,  32'hFFFFFF55, 3'd4, 32'h0,        1'b0, 1'b0};
        vecs[20] = '{1'b0, 32'h10,  32'h0,        3'd0, 32'h55011234, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 32'h12,  32'h0,        3'd0, 32'h0,        1'b1, 1'b1};
        vecs[22] = '{1'b1, 32'h200, 32'hCAFEF00D, 3'd0, 32'h0,        1'b0, 1'b0};
        vecs[23] = '{1'b0, 32'h000, 32'h0,        3'd0, 32'hCAFEF00D, 1'b0, 1'b1};

        rst = 1'b1; req1 = 1'b0; req3 = 1'b0; mem_w = 1'b0;
        addr = 32'd0; wdata = 32'd0; dmtype = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready1), 32'd0);
        check("reset_err", 32'(err1), 32'd0);
        check("reset_rdata", rdata1, 32'd0);
        check("reset_ready3", 32'(ready3), 32'd0);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) begin
            access(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].t, rd, e, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_e));
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // Back-to-back loads with req held high throughout.
        @(negedge clk);
        mem_w = 1'b0; addr = 32'h10; dmtype = 3'd0; req1 = 1'b1;
        c1 = -1; c2 = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ready1) begin c1 = cyc; break; end
        end
        check("b2b_first_rdata", rdata1, 32'h55011234);
        @(posedge clk); #1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ready1) begin c2 = cyc; break; end
        end
        req1 = 1'b0;
        check("b2b_second_rdata", rdata1, 32'h55011234);
        check("b2b_interval", 32'(c2 - c1), 32'd4);
        @(posedge clk); #1;

        // Randomized traffic against the byte-array model.
        last_rd = 32'h55011234;
        for (int wi = 0; wi < 128; wi++) begin
            w32 = $urandom;
            model(1'b1, 32'(wi * 4), w32, 3'd0, erd, ee);
            access(0, 1'b1, 32'(wi * 4), w32, 3'd0, rd, e, lat);
            if (e !== 1'b0) check("init_err", 32'(e), 32'd0);
        end
        for (int k = 0; k < 300; k++) begin
            wr  = 1'($urandom_range(0, 1));
            a32 = $urandom;
            w32 = $urandom;
            tt  = 3'($urandom_range(0, 7));
            model(wr, a32, w32, tt, erd, ee);
            access(0, wr, a32, w32, tt, rd, e, lat);
            check($sformatf("rand%0d_latency", k), 32'(lat), 32'd2);
            check($sformatf("rand%0d_err", k), 32'(e), 32'(ee));
            check($sformatf("rand%0d_rdata", k), rd, erd);
        end

        // WAIT_STATES=3 instance: latency and reset abort in BUSY.
        access(1, 1'b1, 32'h10, 32'hAAAA5555, 3'd0, rd, e, lat);
        check("ws3_store_latency", 32'(lat), 32'd4);
        check("ws3_store_err", 32'(e), 32'd0);
        access(1, 1'b0, 32'h10, 32'h0, 3'd0, rd, e, lat);
        check("ws3_load_latency", 32'(lat), 32'd4);
        check("ws3_load_rdata", rd, 32'hAAAA5555);

        @(negedge clk);
        mem_w = 1'b1; addr = 32'h10; wdata = 32'h12345678; dmtype = 3'd0; req3 = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_ready_low", 32'(ready3), 32'd0);
        check("abort_rdata_reset", rdata3, 32'd0);
        req3 = 1'b0;
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (ready3) seen = 1'b1;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        access(1, 1'b0, 32'h10, 32'h0, 3'd0, rd, e, lat);
        check("abort_load_latency", 32'(lat), 32'd4);
        check("abort_load_rdata", rd, 32'hAAAA5555);
        check("abort_load_err", 32'(e), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
